// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state (even parity, 11-bit frame).
package fifo_uart_pkg;

   localparam int DATA_W           = 8;
   localparam int CLKS_PER_BIT_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud counter: tick marks the last cycle of each serial bit.
// clear restarts the count so the start bit is aligned to the frame.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   // NOTE: always_comb gives every output a value on every path, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) cnt_d = '0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream FIFO and sends 8N1 frames.
// Define FIFO_UART_TX_PARITY_EN for an even-parity bit (8E1).
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_rd,
   output logic              tx,
   output logic              busy
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [2:0]        idx_q, idx_d;
   logic              fifo_rd_q, fifo_rd_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              baud_tick;
   logic              baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   assign baud_clear = (state_q == LOAD);

   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (baud_clear),
      .tick  (baud_tick)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      tx_d    = 1'b1;
      case (state_q)
         IDLE:  if (tx_en && !fifo_empty) state_d = POP;
         POP:   state_d = LOAD;
         LOAD: begin
            shift_d = fifo_dout;
            idx_d   = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_d = ^fifo_dout;
`endif
            state_d = START;
         end
         START: begin
            tx_d = 1'b0;
            if (baud_tick) state_d = DATA;
         end
         DATA: begin
            tx_d = shift_q[0];
            if (baud_tick) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 3'd1;
`ifdef FIFO_UART_TX_PARITY_EN
               if (idx_q == 3'd7) state_d = PARITY;
`else
               if (idx_q == 3'd7) state_d = STOP;
`endif
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: begin
            tx_d = parity_q;
            if (baud_tick) state_d = STOP;
         end
`endif
         STOP:    if (baud_tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // busy also covers the cycle the last stop-bit sample is still on the line
      fifo_rd_d = (state_d == POP);
      busy_d    = (state_d != IDLE) || (state_q != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         idx_q     <= '0;
         fifo_rd_q <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         idx_q     <= idx_d;
         fifo_rd_q <= fifo_rd_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign fifo_rd = fifo_rd_q;
   assign tx      = tx_q;
   assign busy    = busy_q;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 tx_en  input  1  enable; when 1, the block may start new frames.
REQ-005 fifo_empty  input  1  empty flag from the upstream 8-bit FIFO.
REQ-006 fifo_dout  input  8  FIFO read data; valid on the cycle after a pop cycle.
REQ-007 fifo_rd  output  1  pop strobe to the FIFO.
REQ-008 tx  output  1  serial line; idles high.
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 The FSM SHALL have the states IDLE, POP, LOAD, START, DATA, PARITY and STOP.
REQ-011 IDLE->POP on an edge with tx_en=1 and fifo_empty=0; otherwise the FSM SHALL hold IDLE.
REQ-012 fifo_rd SHALL be 1 only while in POP, for exactly one cycle per frame, and never while fifo_empty=1.
REQ-013 POP->LOAD unconditionally; LOAD SHALL capture fifo_dout into an 8-bit shift register, then go to START.
REQ-014 tx SHALL be 0 in START, the current shift-register LSB in DATA, the parity bit in PARITY, and 1 in IDLE/POP/LOAD/STOP.
REQ-015 START, each DATA bit, PARITY and STOP SHALL each last exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at every bit boundary.
REQ-016 DATA SHALL send 8 bits LSB first, using a 3-bit index; DATA exits after index 7 to PARITY (if compiled in) or STOP.
REQ-017 STOP->IDLE after its final cycle; with the FIFO non-empty, the inter-frame gap SHALL be exactly 3 tx-high cycles (IDLE, POP, LOAD) plus the stop bit.
REQ-018 tx falling edge SHALL occur exactly 3 edges after the edge that samples fifo_empty=0 in IDLE.
REQ-019 A tx_en deassertion mid-frame SHALL NOT abort the frame; the block SHALL stop in IDLE after STOP.
REQ-020 The connected FIFO SHALL complete a pop on every cycle with fifo_rd=1 and fifo_empty=0, including during simultaneous writes; FIFOs that give writes priority over reads are not compatible.
REQ-021 The block SHALL NOT look at fifo_empty outside IDLE.

Reset
REQ-022 While rst=1: state=IDLE, tx=1, fifo_rd=0, busy=0, counters=0, shift register=0; all of these SHALL take effect asynchronously.
REQ-023 Reset mid-frame SHALL drop the in-flight byte with no further pop; after release the block SHALL resume at REQ-011.

Configuration
REQ-024 Macro FIFO_UART_TX_PARITY_EN: when defined, PARITY is in the state set and carries even parity (XOR of the 8 data bits), giving an 11-bit frame.
REQ-025 When FIFO_UART_TX_PARITY_EN is undefined, PARITY SHALL be absent, DATA SHALL go directly to STOP, and the frame SHALL be 10 bits.

Structure
REQ-026 Package fifo_uart_pkg SHALL hold the state enum typedef, the DATA_W=8 constant and the default CLKS_PER_BIT.
REQ-027 One sub-module, uart_baud_cnt, SHALL provide the bit-boundary tick; it has a clear input asserted on the LOAD->START transition.

Verification (CLKS_PER_BIT=4)
REQ-028 Single byte: FIFO holds 0xA5, no parity -> one fifo_rd pulse; tx=0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1; busy high for 43 cycles.
REQ-029 Parity: same test with FIFO_UART_TX_PARITY_EN and byte 0x07 -> the parity bit is 1 and the frame is 44 cycles.
REQ-030 Back-to-back: FIFO holds 0x00, 0xFF -> exactly 2 fifo_rd pulses; 3 high cycles between the stop bit and the next start bit.
REQ-031 Empty FIFO: fifo_empty=1 for 100 cycles -> fifo_rd=0 and tx=1 throughout.
REQ-032 tx_en dropped during DATA bit 3 of 0x3C -> the frame completes intact; no further pop while 2 bytes remain queued.
REQ-033 rst pulsed during DATA bit 5 -> tx=1 in the same cycle; after release the next queued byte is sent complete.
